s1_cfg_loader: RTL and testbench
================================

# s1_cfg_loader

Serial configuration loader that sits directly upstream of the S1 logic-cell array and drives each cell's four data inputs (D00, D01, D10, D11). It accepts a serial bitstream over a valid/ready handshake, assembles it in a shadow register and checks an even-parity trailer bit. Only a passing frame is committed atomically to the parallel `cfg` bus feeding the cells; a failing frame leaves the previous configuration untouched.

## Interface

- `N_CELLS`, default 8: number of S1 cells configured. Must be ≥1.
- `CFG_W`, derived as 4*N_CELLS, not overridable: configuration width.

Ports:

- `clk` input 1: rising-edge clock.
- `clr_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a frame; sampled only in IDLE.
- `sin_valid` input 1: serial bit present.
- `sin_data` input 1: serial bit.
- `sin_ready` output 1: loader accepts a bit this cycle.
- `cfg` output CFG_W: committed configuration. `cfg[4i+3:4i]` = {D11, D10, D01, D00} of cell i.
- `cfg_valid` output 1: at least one frame committed since reset.
- `busy` output 1: FSM not in IDLE.
- `done` output 1: one-cycle pulse on successful commit.
- `err` output 1: last frame failed parity; sticky.

## Operation

- One clock; reset is asynchronous, active-low (`clk`, `clr_n`).
- Reset values: `cfg`=0, `cfg_valid`=0, `sin_ready`=0, `busy`=0, `done`=0, `err`=0, FSM=IDLE, bit counter=0, shadow=0.
- FSM states: IDLE, SHIFT, PARITY, COMMIT.
  - IDLE: `start`=1 → SHIFT. Clear `err` and the counter; the shadow register is not cleared.
  - SHIFT: each accepted bit (`sin_valid & sin_ready`) shifts into the shadow register LSB, shifting left. The first bit received ends at `shadow[CFG_W-1]`. The counter increments, and on the CFG_W-th accepted bit the FSM moves → PARITY.
  - PARITY: the next accepted bit is the parity bit p. If `^shadow ^ p == 0` → COMMIT. Otherwise set `err`=1 → IDLE, with `cfg` unchanged.
  - COMMIT: `cfg` <= shadow, `cfg_valid` <= 1, `done`=1 for this cycle only → IDLE.
- `sin_ready` = 1 in SHIFT and PARITY only; 0 in IDLE and COMMIT.
- `sin_valid` low stalls the frame indefinitely with no timeout; state and counter are held.
- `start` is ignored while `busy`=1. Bits presented in IDLE are not accepted and are dropped.
- Counter width: clog2(CFG_W+1). It wraps only through return to IDLE.
- `cfg` changes only in COMMIT or on reset, so the cells never see a partial frame.
- `clr_n` low at any point, including mid-frame, immediately forces all reset values. The frame is lost, and `cfg` returns to 0 (all cells output 0 via D inputs).

## Timing

- `busy` rises the cycle after `start` is sampled in IDLE. `sin_ready` rises in the same cycle.
- Minimum frame time with `sin_valid` held high: 1 (start) + CFG_W + 1 (parity) + 1 (COMMIT) cycles from the start edge until the return to IDLE.
- `cfg` and `done` update on the edge leaving PARITY. `cfg` is visible on the following cycle, which is the same cycle `done`=1.
- `err` asserts in the cycle after the parity bit is accepted and remains high until the next accepted `start`.
- `start` asserted in the COMMIT cycle is ignored. `start` asserted in the first IDLE cycle after COMMIT is accepted, giving back-to-back frames with one IDLE gap.
- All outputs are registered.

## Test plan

- **Reset:** assert `clr_n`=0 asynchronously mid-cycle → all outputs 0 immediately, before the next clock edge.
- **Good frame** (N_CELLS=2): `start`, bits 1,0,1,1,0,0,1,0, parity 0 → `cfg`=8'hB2, `done` pulses once, `cfg_valid`=1, `err`=0, 11 cycles start-to-IDLE.
- **Bad parity:** after the good frame, send bits 8'hFF with parity 1 → `err`=1, no `done`, `cfg` remains 8'hB2. The next `start` clears `err`.
- **Stall:** good frame with `sin_valid` dropped for 5 cycles after bit 3 → `sin_ready` stays 1, the counter holds, and the final `cfg` equals the unstalled result with the frame 5 cycles longer.
- **Ignored inputs:** `start` pulsed during SHIFT and bits driven in IDLE → no restart, no shift, same `cfg` as the clean run.
- **Mid-frame reset:** `clr_n` low after bit 5 of a frame for 8'h5A, then release → `cfg`=0, FSM in IDLE. A subsequent full 8'h5A frame with parity 0 commits 8'h5A.

Source files
------------

// File: rtl/s1_cfg_loader_if.sv
// Serial bit stream handshake into the S1 configuration loader.
// The source drives valid/data; the loader returns ready.
interface s1_cfg_loader_if;
    logic sin_valid;
    logic sin_data;
    logic sin_ready;

    modport master (output sin_valid, output sin_data, input sin_ready);
    modport slave  (input sin_valid, input sin_data, output sin_ready);
endinterface

// File: rtl/s1_cfg_loader.sv
// Serial configuration loader for the S1 cell array: shifts a frame into a shadow
// register, checks an even-parity trailer and commits the frame atomically to cfg.
module s1_cfg_loader #(
    parameter int N_CELLS = 8,
    localparam int CFG_W = 4 * N_CELLS
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    s1_cfg_loader_if.slave   sin,
    output logic [CFG_W-1:0] cfg,
    output logic             cfg_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, COMMIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CFG_W-1:0] shadow;
    logic             acc;
    logic             par_ok;

    assign acc    = sin.sin_valid & sin.sin_ready;
    assign par_ok = ~(^shadow ^ sin.sin_data);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (acc && cnt == LAST) state_nxt = PARITY;
            PARITY:  if (acc) state_nxt = par_ok ? COMMIT : IDLE;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the FSM.
    // cfg is loaded on the edge leaving PARITY so it is already visible while done=1.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt           <= '0;
            shadow        <= '0;
            cfg           <= '0;
            cfg_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            sin.sin_ready <= 1'b0;
        end else begin
            busy          <= (state_nxt != IDLE);
            sin.sin_ready <= (state_nxt == SHIFT) || (state_nxt == PARITY);
            done          <= (state_nxt == COMMIT);
            if (state == IDLE && start) begin
                cnt <= '0;
                err <= 1'b0;
            end
            if (state == SHIFT && acc) begin
                shadow <= {shadow[CFG_W-2:0], sin.sin_data};
                cnt    <= cnt + 1'b1;
            end
            if (state == PARITY && acc) begin
                if (par_ok) begin
                    cfg       <= shadow;
                    cfg_valid <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_s1_cfg_loader.sv
// Randomized self-checking bench for s1_cfg_loader against a frame-level reference model.
module tb_s1_cfg_loader;
    localparam int N_CELLS = 2;
    localparam int CFG_W   = 4 * N_CELLS;

    logic             clk   = 1'b0;
    logic             clr_n = 1'b0;
    logic             start = 1'b0;
    logic [CFG_W-1:0] cfg;
    logic             cfg_valid, busy, done, err;

    s1_cfg_loader_if sif ();

    s1_cfg_loader #(.N_CELLS(N_CELLS)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .sin       (sif.slave),
        .cfg       (cfg),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [CFG_W-1:0] m_cfg   = '0;
    logic             m_valid = 1'b0;
    logic             m_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_cfg"},   32'(cfg),       32'(m_cfg));
        chk({tag, "_valid"}, 32'(cfg_valid), 32'(m_valid));
        chk({tag, "_err"},   32'(err),       32'(m_err));
    endtask

    // Idle cycles with junk on the serial lines; nothing may be accepted.
    task automatic idle(input int n);
        repeat (n) begin
            sif.sin_valid = 1'($urandom);
            sif.sin_data  = 1'($urandom);
            @(posedge clk); #1;
            chk("idle_rdy",  32'(sif.sin_ready), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_cfg",  32'(cfg), 32'(m_cfg));
        end
        sif.sin_valid = 1'b0;
    endtask

    // One frame, MSB first, then parity. Optional stall before bit stall_at,
    // start pulses during SHIFT and in the COMMIT cycle (both must be ignored).
    task automatic send_frame(input logic [CFG_W-1:0] data, input logic p,
                              input int stall_at, input int stall_len,
                              input bit start_in_shift, input bit start_in_commit);
        int  bc;
        int  stalls;
        bit  good;
        logic b;
        bc     = 0;
        stalls = 0;
        good   = (($countones(data) + int'(p)) % 2) == 0;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        m_err  = 1'b0;
        chk("busy_rise", 32'(busy), 1);
        chk("rdy_rise",  32'(sif.sin_ready), 1);
        chk("err_clr",   32'(err), 0);
        bc += int'(busy);
        for (int i = 0; i <= CFG_W; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    sif.sin_valid = 1'b0;
                    sif.sin_data  = 1'($urandom);
                    start = start_in_shift;
                    @(posedge clk); #1;
                    start = 1'b0;
                    chk("stall_rdy", 32'(sif.sin_ready), 1);
                    chk("stall_cfg", 32'(cfg), 32'(m_cfg));
                    bc += int'(busy);
                    stalls++;
                end
            end
            b = (i < CFG_W) ? data[CFG_W-1-i] : p;
            sif.sin_valid = 1'b1;
            sif.sin_data  = b;
            if (start_in_shift && i == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            bc += int'(busy);
            if (i < CFG_W - 1) chk("mid_cfg", 32'(cfg), 32'(m_cfg));
        end
        sif.sin_valid = 1'b0;
        if (good) begin
            m_cfg   = data;
            m_valid = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        chk("done", 32'(done), 32'(good));
        chk_outputs("post_par");
        if (good) begin
            start = start_in_commit;
            @(posedge clk); #1;
            start = 1'b0;
            chk("done_pulse", 32'(done), 0);
            chk_outputs("commit");
        end
        chk("busy_cyc", 32'(bc), 32'(CFG_W + 1 + int'(good) + stalls));
        chk("end_idle", 32'(busy), 0);
        chk("end_rdy",  32'(sif.sin_ready), 0);
        if (good && start_in_commit) begin
            @(posedge clk); #1;
            chk("commit_start_ign", 32'(busy), 0);
        end
    endtask

    initial begin
        logic [CFG_W-1:0] d;
        logic             p;
        int               st;
        sif.sin_valid = 1'b0;
        sif.sin_data  = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdy",  32'(sif.sin_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk_outputs("rst");
        clr_n = 1'b1;
        @(posedge clk); #1;

        send_frame(8'hB2, 1'b0, -1, 0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, -1, 0, 1'b0, 1'b0);
        idle(1);
        send_frame(8'hB2, 1'b0, 3, 5, 1'b0, 1'b0);
        idle(4);
        send_frame(8'hB2, 1'b0, 4, 2, 1'b1, 1'b1);

        // Mid-frame asynchronous reset after 5 bits of 8'h5A
        d = 8'h5A;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sif.sin_valid = 1'b1;
            sif.sin_data  = d[CFG_W-1-i];
            @(posedge clk); #1;
        end
        #3 clr_n = 1'b0;
        #1;
        m_cfg = '0; m_valid = 1'b0; m_err = 1'b0;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rdy",  32'(sif.sin_ready), 0);
        chk("arst_done", 32'(done), 0);
        chk_outputs("arst");
        sif.sin_valid = 1'b0;
        #2 clr_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle", 32'(busy), 0);
        send_frame(8'h5A, 1'b0, -1, 0, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            d  = CFG_W'($urandom);
            p  = 1'($countones(d) % 2);
            if ($urandom_range(0, 4) == 0) p = ~p;
            st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, CFG_W)) : -1;
            send_frame(d, p, st, int'($urandom_range(1, 4)),
                       1'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
